// File: rtl/mem_axi_master_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI4-Lite master bridge.
package mem_axi_master_bridge_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_AR   = 4'd1,
    S_R    = 4'd2,
    S_WR   = 4'd3,
    S_B    = 4'd4,
    S_DONE = 4'd5
  } state_e;

  localparam logic [31:0] ERR_RDATA  = 32'hdeadbeef;
  localparam logic [2:0]  PROT_DATA  = 3'b000;
  localparam logic [2:0]  PROT_INSTR = 3'b100;

endpackage

// File: rtl/mem_axi_if.sv
// AXI4-Lite master/slave bundle (AW, W, B, AR, R channels).
interface mem_axi_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready, bvalid,
    input  arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready, bvalid,
    output arready, rvalid, rdata
  );

endinterface

// File: rtl/mem_axi_master_bridge.sv
// CPU native memory port to AXI4-Lite master, one access in flight.
// Optional response timeout: MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN.
module mem_axi_master_bridge
  import mem_axi_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_W      = 9
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  mem_axi_if.master   mem_axi
);

  if (2 ** TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  prot_q, prot_d;
  logic        aw_ok, w_ok;

`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_err_q, bus_err_d;
  logic                 busy, expire;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= S_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    mem_ready_d = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    aw_ok       = !awvalid_q || mem_axi.awready;
    w_ok        = !wvalid_q || mem_axi.wready;

    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          prot_d  = mem_instr ? PROT_INSTR : PROT_DATA;
          if (mem_wstrb == 4'b0000) begin
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end
        end
      end
      S_AR: begin
        if (mem_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        if (mem_axi.rvalid) begin
          rdata_d     = mem_axi.rdata;
          rready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_WR: begin
        // AW and W retire independently; B opens once both have.
        if (mem_axi.awready) awvalid_d = 1'b0;
        if (mem_axi.wready)  wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (mem_axi.bvalid) begin
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
    bus_err_d = 1'b0;
    busy      = state_q inside {S_AR, S_R, S_WR, S_B};
    cnt_d     = cnt_q;
    if (state_q == S_IDLE) cnt_d = '0;
    else if (busy)         cnt_d = cnt_q + 1'b1;
    // A state-advancing handshake on the expiry cycle wins.
    expire = busy && (cnt_q >= TO_LAST) && (state_d == state_q);
    if (expire) begin
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      mem_ready_d = 1'b1;
      bus_err_d   = 1'b1;
      state_d     = S_DONE;
      if (state_q inside {S_AR, S_R}) rdata_d = ERR_RDATA;
    end
`endif
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = rdata_q;
`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
  assign bus_err         = bus_err_q;
`else
  assign bus_err         = 1'b0;
`endif

  assign mem_axi.arvalid = arvalid_q;
  assign mem_axi.araddr  = addr_q;
  assign mem_axi.arprot  = prot_q;
  assign mem_axi.rready  = rready_q;
  assign mem_axi.awvalid = awvalid_q;
  assign mem_axi.awaddr  = addr_q;
  assign mem_axi.awprot  = prot_q;
  assign mem_axi.wvalid  = wvalid_q;
  assign mem_axi.wdata   = wdata_q;
  assign mem_axi.wstrb   = wstrb_q;
  assign mem_axi.bready  = bready_q;

endmodule

// File: tb/tb_mem_axi_master_bridge.sv
// Randomized scoreboard bench for mem_axi_master_bridge with a
// behavioural AXI4-Lite slave and word-array memory model.
module tb_mem_axi_master_bridge;

  logic        CLK;
  logic        RSTb;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;

  mem_axi_if axi();

  mem_axi_master_bridge #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_W(9)
  ) dut (
    .CLK(CLK),
    .RSTb(RSTb),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .bus_err(bus_err),
    .mem_axi(axi)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  int          checks;
  int          failures;
  exp_t        sb[$];
  logic [31:0] model [64];
  logic [31:0] smem  [64];
  logic [31:0] last_rd;
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  int          lat;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // AXI4-Lite slave: ready/valid pulses are set on the falling edge.
  initial begin
    int rd_ph, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit aw_got, w_got, aw_pl, w_pl, b_pl;
    logic [5:0] wi;
    rd_ph = 0; ar_cnt = 0; r_cnt = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_got = 0; w_got = 0; aw_pl = 0; w_pl = 0; b_pl = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    forever begin
      @(negedge CLK);
      if (!RSTb) begin
        rd_ph = 0; ar_cnt = 0; r_cnt = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 0; w_got = 0; aw_pl = 0; w_pl = 0; b_pl = 0;
        axi.arready = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        continue;
      end
      if (axi.bready)
        chk("bready_early", {31'd0, aw_got && w_got}, 32'd1);
      if (rd_ph == 1) begin
        chk("arvalid_drop", {31'd0, axi.arvalid}, 32'd0);
        axi.arready = 0; rd_ph = 2; r_cnt = 0;
      end else if (rd_ph == 3) begin
        chk("rready_drop", {31'd0, axi.rready}, 32'd0);
        axi.rvalid = 0; rd_ph = 0;
      end
      if (rd_ph == 0) begin
        if (!axi.arvalid) ar_cnt = 0;
        else if (ar_cnt >= ar_dly) begin
          axi.arready = 1; rd_ph = 1;
        end else ar_cnt++;
      end else if (rd_ph == 2 && axi.rready) begin
        if (r_cnt >= r_dly) begin
          axi.rvalid = 1;
          axi.rdata  = smem[axi.araddr[7:2]];
          rd_ph = 3;
        end else r_cnt++;
      end
      if (aw_pl) begin
        chk("awvalid_drop", {31'd0, axi.awvalid}, 32'd0);
        axi.awready = 0; aw_pl = 0;
      end
      if (w_pl) begin
        chk("wvalid_drop", {31'd0, axi.wvalid}, 32'd0);
        axi.wready = 0; w_pl = 0;
      end
      if (b_pl) begin
        chk("bready_drop", {31'd0, axi.bready}, 32'd0);
        axi.bvalid = 0; b_pl = 0;
        aw_got = 0; w_got = 0; b_cnt = 0;
      end
      if (!aw_got) begin
        if (!axi.awvalid) aw_cnt = 0;
        else if (aw_cnt >= aw_dly) begin
          axi.awready = 1; aw_got = 1; aw_pl = 1;
        end else aw_cnt++;
      end
      if (!w_got) begin
        if (!axi.wvalid) w_cnt = 0;
        else if (w_cnt >= w_dly) begin
          axi.wready = 1; w_got = 1; w_pl = 1;
        end else w_cnt++;
      end
      if (aw_got && w_got && !aw_pl && !w_pl && !b_pl && axi.bready) begin
        if (b_cnt >= b_dly) begin
          axi.bvalid = 1; b_pl = 1;
          wi = axi.awaddr[7:2];
          for (int b = 0; b < 4; b++)
            if (axi.wstrb[b]) smem[wi][8*b +: 8] = axi.wdata[8*b +: 8];
        end else b_cnt++;
      end
    end
  end

  // Scoreboard monitor: checks payloads in flight and pops on mem_ready.
  initial begin
    bit   prev_rdy;
    exp_t e;
    prev_rdy = 0;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb[0];
        if (axi.arvalid || axi.rready) begin
          chk("rd_chan_kind", {31'd0, e.wr}, 32'd0);
          chk("araddr", axi.araddr, e.addr);
          chk("arprot", {29'd0, axi.arprot}, {29'd0, e.prot});
        end
        if (axi.awvalid || axi.wvalid || axi.bready) begin
          chk("wr_chan_kind", {31'd0, e.wr}, 32'd1);
          chk("awaddr", axi.awaddr, e.addr);
          chk("awprot", {29'd0, axi.awprot}, {29'd0, e.prot});
          chk("wdata", axi.wdata, e.wdata);
          chk("wstrb", {28'd0, axi.wstrb}, {28'd0, e.wstrb});
        end
      end
      if (mem_ready) begin
        chk("ready_one_cycle", {31'd0, prev_rdy}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready got=1 exp=0");
        end else begin
          e = sb.pop_front();
          chk("mem_rdata", mem_rdata, e.rdata);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        end
      end
      prev_rdy = mem_ready;
    end
  end

  task automatic do_req(input bit wr, input bit instr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit to_exp,
                        output int latency);
    exp_t e;
    int   n;
    e.wr    = wr;
    e.addr  = addr;
    e.prot  = instr ? 3'b100 : 3'b000;
    e.wdata = wdata;
    e.wstrb = wr ? strb : 4'b0000;
    e.err   = to_exp;
    if (to_exp) begin
      e.rdata = wr ? last_rd : 32'hdeadbeef;
    end else if (!wr) begin
      e.rdata = model[addr[7:2]];
    end else begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      e.rdata = last_rd;
    end
    last_rd = e.rdata;
    sb.push_back(e);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = e.wstrb;
    n = 0;
    while (1) begin
      @(negedge CLK);
      n++;
      if (mem_ready) break;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL req_timeout got=%0d exp<=100", n);
        finish_run();
      end
    end
    latency = n - 1;
    @(posedge CLK);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic set_dly(input int ar, input int r, input int aw,
                         input int w, input int b);
    ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  initial begin
    bit          wr, instr;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          n;
    checks = 0; failures = 0; last_rd = '0;
    RSTb = 1'b0; mem_valid = 0; mem_instr = 0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    set_dly(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      model[i] = 32'h1000_0000 + i * 32'h0101_0101;
      smem[i]  = model[i];
    end
    model[4] = 32'h1234_5678;
    smem[4]  = 32'h1234_5678;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valids", {26'd0, axi.arvalid, axi.rready, axi.awvalid,
        axi.wvalid, axi.bready, mem_ready}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addr", axi.araddr | axi.awaddr, 32'd0);
    chk("rst_wdata", axi.wdata, 32'd0);
    RSTb = 1'b1;
    @(posedge CLK);
    #1;

    set_dly(0, 0, 0, 0, 0);
    do_req(0, 0, 32'h0000_0020, '0, '0, 0, lat);
    chk("latency_min_rd", lat, 3);
    do_req(1, 0, 32'h0000_0024, 32'h0bad_f00d, 4'hf, 0, lat);
    chk("latency_min_wr", lat, 3);

    set_dly(1, 2, 0, 0, 0);
    do_req(0, 0, 32'h0000_0010, '0, '0, 0, lat);
    chk("latency_rd_wait", lat, 6);
    set_dly(0, 0, 0, 0, 0);
    do_req(0, 1, 32'h0000_0000, '0, '0, 0, lat);

    set_dly(0, 0, 1, 3, 0);
    do_req(1, 0, 32'h1000_0004, 32'hcafe_f00d, 4'b0011, 0, lat);
    chk("latency_wr_wait", lat, 6);
    do_req(0, 0, 32'h0000_0004, '0, '0, 0, lat);
    set_dly(0, 0, 3, 0, 1);
    do_req(1, 0, 32'h0000_0008, 32'h5555_aaaa, 4'b1100, 0, lat);
    set_dly(0, 0, 2, 2, 0);
    do_req(1, 1, 32'h0000_000b, 32'h0123_4567, 4'b0101, 0, lat);
    set_dly(0, 0, 0, 0, 0);
    do_req(0, 0, 32'h0000_0008, '0, '0, 0, lat);

    // Reset in the middle of a read's R phase.
    set_dly(0, 20, 0, 0, 0);
    mem_valid = 1'b1; mem_instr = 0;
    mem_addr = 32'h0000_0030; mem_wstrb = 4'b0000;
    n = 0;
    while (!axi.rready) begin
      @(negedge CLK);
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL rready_wait got=0 exp=1");
        finish_run();
      end
    end
    #2;
    RSTb = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("midrst_valids", {26'd0, axi.arvalid, axi.rready, axi.awvalid,
        axi.wvalid, axi.bready, mem_ready}, 32'd0);
    chk("midrst_rdata", mem_rdata, 32'd0);
    chk("midrst_addr", axi.araddr, 32'd0);
    last_rd = '0;
    repeat (2) @(posedge CLK);
    #1;
    RSTb = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    set_dly(0, 0, 0, 0, 0);
    do_req(0, 0, 32'h0000_0030, '0, '0, 0, lat);
    chk("post_rst_latency", lat, 3);

`ifdef MEM_AXI_MASTER_BRIDGE_TIMEOUT_EN
    set_dly(1000, 0, 0, 0, 0);
    do_req(0, 0, 32'h0000_0040, '0, '0, 1, lat);
    chk("timeout_latency", lat, 9);
    set_dly(0, 0, 0, 0, 0);
    do_req(0, 0, 32'h0000_0040, '0, '0, 0, lat);
`endif

    for (int i = 0; i < 60; i++) begin
      set_dly($urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2));
      wr    = 1'($urandom_range(0, 1));
      instr = !wr && ($urandom_range(0, 1) == 1);
      a     = $urandom & 32'h0000_00ff;
      d     = $urandom;
      s     = wr ? 4'($urandom_range(1, 15)) : 4'b0000;
      do_req(wr, instr, a, d, s, 0, lat);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    repeat (5) @(posedge CLK);
    chk("sb_drained", sb.size(), 32'd0);
    finish_run();
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
